// File: rtl/uart_tx_engine.sv
// uart_tx_engine: serialises one byte per valid/ready handshake into an
// asynchronous UART frame (start, 8 data bits LSB first, optional parity, stop)
// and pulses tx_done for one cycle when the stop bit finishes.
module uart_tx_engine #(
   parameter int CLKS_PER_BIT = 868,
   parameter int PARITY       = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       tx_done
);

   localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
   // Any PARITY value other than 1 or 2 means no parity bit is sent.
   localparam bit               PAR_EN  = (PARITY == 1) || (PARITY == 2);
   localparam bit               PAR_ODD = (PARITY == 2);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY_BIT,
      STOP
   } state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
   logic [2:0]       bit_idx, bit_idx_n;
   logic [7:0]       shreg, shreg_n;
   logic             par_bit, par_bit_n;
   logic             tx_n, tx_ready_n, tx_done_n;
   logic             bit_end;

   assign bit_end = (baud_cnt == CNT_MAX);

   // Next-state and next-output logic; tx/tx_ready/tx_done are computed one
   // cycle ahead so the registered outputs change on the same edge as the state.
   always_comb begin
      state_n    = state;
      baud_cnt_n = baud_cnt;
      bit_idx_n  = bit_idx;
      shreg_n    = shreg;
      par_bit_n  = par_bit;
      tx_n       = tx;
      tx_ready_n = tx_ready;
      tx_done_n  = 1'b0;

      case (state)
         IDLE: begin
            baud_cnt_n = '0;
            if (tx_valid && tx_ready) begin
               shreg_n    = tx_data;
               par_bit_n  = (^tx_data) ^ PAR_ODD;
               bit_idx_n  = '0;
               state_n    = START;
               tx_n       = 1'b0;
               tx_ready_n = 1'b0;
            end
         end

         START: begin
            if (bit_end) begin
               baud_cnt_n = '0;
               bit_idx_n  = '0;
               state_n    = DATA;
               tx_n       = shreg[0];
               shreg_n    = {1'b0, shreg[7:1]};
            end else begin
               baud_cnt_n = baud_cnt + CNT_W'(1);
            end
         end

         DATA: begin
            if (bit_end) begin
               baud_cnt_n = '0;
               if (bit_idx == 3'd7) begin
                  if (PAR_EN) begin
                     state_n = PARITY_BIT;
                     tx_n    = par_bit;
                  end else begin
                     state_n = STOP;
                     tx_n    = 1'b1;
                  end
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
                  tx_n      = shreg[0];
                  shreg_n   = {1'b0, shreg[7:1]};
               end
            end else begin
               baud_cnt_n = baud_cnt + CNT_W'(1);
            end
         end

         PARITY_BIT: begin
            if (bit_end) begin
               baud_cnt_n = '0;
               state_n    = STOP;
               tx_n       = 1'b1;
            end else begin
               baud_cnt_n = baud_cnt + CNT_W'(1);
            end
         end

         STOP: begin
            if (bit_end) begin
               baud_cnt_n = '0;
               state_n    = IDLE;
               tx_n       = 1'b1;
               tx_ready_n = 1'b1;
               tx_done_n  = 1'b1;
            end else begin
               baud_cnt_n = baud_cnt + CNT_W'(1);
            end
         end

         default: begin
            baud_cnt_n = '0;
            state_n    = IDLE;
            tx_n       = 1'b1;
            tx_ready_n = 1'b1;
         end
      endcase
   end

   // State, datapath and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         par_bit  <= 1'b0;
         tx       <= 1'b1;
         tx_ready <= 1'b1;
         tx_done  <= 1'b0;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_cnt_n;
         bit_idx  <= bit_idx_n;
         shreg    <= shreg_n;
         par_bit  <= par_bit_n;
         tx       <= tx_n;
         tx_ready <= tx_ready_n;
         tx_done  <= tx_done_n;
      end
   end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: three engines (no, even, odd parity) at 4 clocks per bit,
// checked cycle by cycle against a frame-level waveform model.
module tb_uart_tx_engine;

   localparam int C = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [2:0]  valid_all = '0;
   logic [23:0] data_all = '0;
   logic [2:0]  tx_o, ready_o, done_o;

   int checks = 0;
   int errors = 0;

   logic cap_tx [0:127];
   logic cap_ready [0:127];
   logic cap_done [0:127];
   logic exp_tx [0:127];
   logic exp_ready [0:127];
   logic exp_done [0:127];

   uart_tx_engine #(.CLKS_PER_BIT(C), .PARITY(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .tx_data(data_all[7:0]), .tx_valid(valid_all[0]),
      .tx_ready(ready_o[0]), .tx(tx_o[0]), .tx_done(done_o[0]));
   uart_tx_engine #(.CLKS_PER_BIT(C), .PARITY(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .tx_data(data_all[15:8]), .tx_valid(valid_all[1]),
      .tx_ready(ready_o[1]), .tx(tx_o[1]), .tx_done(done_o[1]));
   uart_tx_engine #(.CLKS_PER_BIT(C), .PARITY(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .tx_data(data_all[23:16]), .tx_valid(valid_all[2]),
      .tx_ready(ready_o[2]), .tx(tx_o[2]), .tx_done(done_o[2]));

   always #5 clk = ~clk;

   // Reference model: line is idle-high and ready outside frames.
   task automatic clear_expect();
      for (int t = 0; t < 128; t++) begin
         exp_tx[t] = 1'b1; exp_ready[t] = 1'b1; exp_done[t] = 1'b0;
      end
   endtask

   // Reference model: a frame accepted so that cycle 'start' is its first start-bit cycle.
   task automatic model_frame(input int start, input logic [7:0] d, input int pm);
      logic [10:0] f;
      int n;
      n = (pm == 1 || pm == 2) ? 11 : 10;
      f = '1;
      f[0] = 1'b0;
      f[8:1] = d;
      if (n == 11) f[9] = (pm == 1) ? ^d : ~^d;
      for (int t = 0; t < n * C; t++) begin
         exp_tx[start + t] = f[t / C];
         exp_ready[start + t] = 1'b0;
      end
      exp_done[start + n * C] = 1'b1;
   endtask

   // Present a byte at a falling edge; returns just after the accepting rising edge.
   task automatic launch(input int inst, input logic [7:0] d);
      @(negedge clk);
      valid_all[inst] = 1'b1;
      data_all[inst*8 +: 8] = d;
      @(posedge clk);
   endtask

   // Records outputs at n successive falling edges; sample 0 follows the accept edge.
   task automatic capture(input int inst, input int n);
      for (int t = 0; t < n; t++) begin
         @(negedge clk);
         cap_tx[t] = tx_o[inst];
         cap_ready[t] = ready_o[inst];
         cap_done[t] = done_o[inst];
      end
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({tx_o[i], ready_o[i], done_o[i]} !== 3'b110) begin
            errors++;
            $display("FAIL reset_async inst %0d: got tx/ready/done %b expected 110", i, {tx_o[i], ready_o[i], done_o[i]});
         end
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int t = 0; t < 12; t++) begin
         @(negedge clk);
         checks++;
         if ({tx_o, ready_o, done_o} !== 9'b111_111_000) begin
            errors++;
            $display("FAIL reset_idle cycle %0d: got %b expected 111111000", t, {tx_o, ready_o, done_o});
         end
      end
   endtask

   task automatic test_single_frame();
      launch(0, 8'h55);
      fork
         capture(0, 46);
         begin @(negedge clk); valid_all[0] = 1'b0; end
      join
      clear_expect();
      model_frame(0, 8'h55, 0);
      for (int t = 0; t < 46; t++) begin
         checks++;
         if (cap_tx[t] !== exp_tx[t] || cap_ready[t] !== exp_ready[t] || cap_done[t] !== exp_done[t]) begin
            errors++;
            $display("FAIL single_frame cycle %0d: got tx/ready/done %b%b%b expected %b%b%b", t,
                     cap_tx[t], cap_ready[t], cap_done[t], exp_tx[t], exp_ready[t], exp_done[t]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] b1, b2;
      int pulses;
      launch(0, 8'hA3);
      fork
         capture(0, 88);
         begin
            @(negedge clk); data_all[7:0] = 8'h0F;
            repeat (41) @(negedge clk);
            valid_all[0] = 1'b0;
         end
      join
      clear_expect();
      model_frame(0, 8'hA3, 0);
      model_frame(10 * C + 1, 8'h0F, 0);
      pulses = 0;
      for (int t = 0; t < 88; t++) begin
         if (cap_done[t] === 1'b1) pulses++;
         checks++;
         if (cap_tx[t] !== exp_tx[t] || cap_ready[t] !== exp_ready[t] || cap_done[t] !== exp_done[t]) begin
            errors++;
            $display("FAIL back_to_back cycle %0d: got tx/ready/done %b%b%b expected %b%b%b", t,
                     cap_tx[t], cap_ready[t], cap_done[t], exp_tx[t], exp_ready[t], exp_done[t]);
         end
      end
      for (int i = 0; i < 8; i++) begin
         b1[i] = cap_tx[C + C * i + 2];
         b2[i] = cap_tx[41 + C + C * i + 2];
      end
      checks++;
      if (b1 !== 8'hA3 || b2 !== 8'h0F) begin
         errors++;
         $display("FAIL back_to_back_decode: got %h %h expected a3 0f", b1, b2);
      end
      checks++;
      if (pulses != 2) begin
         errors++;
         $display("FAIL back_to_back_done_count: got %0d expected 2", pulses);
      end
   endtask

   task automatic test_parity();
      int         inst_c [3] = '{1, 2, 2};
      logic [7:0] data_c [3] = '{8'h07, 8'h07, 8'h00};
      logic       pexp_c [3] = '{1'b1, 1'b0, 1'b1};
      for (int k = 0; k < 3; k++) begin
         repeat (2) @(negedge clk);
         launch(inst_c[k], data_c[k]);
         fork
            capture(inst_c[k], 48);
            begin @(negedge clk); valid_all[inst_c[k]] = 1'b0; end
         join
         clear_expect();
         model_frame(0, data_c[k], inst_c[k]);
         for (int t = 0; t < 48; t++) begin
            checks++;
            if (cap_tx[t] !== exp_tx[t] || cap_ready[t] !== exp_ready[t] || cap_done[t] !== exp_done[t]) begin
               errors++;
               $display("FAIL parity case %0d cycle %0d: got tx/ready/done %b%b%b expected %b%b%b", k, t,
                        cap_tx[t], cap_ready[t], cap_done[t], exp_tx[t], exp_ready[t], exp_done[t]);
            end
         end
         checks++;
         if (cap_tx[9 * C + 2] !== pexp_c[k] || cap_done[44] !== 1'b1) begin
            errors++;
            $display("FAIL parity_bit case %0d: got bit %b done@44 %b expected %b 1", k,
                     cap_tx[9 * C + 2], cap_done[44], pexp_c[k]);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int rst_cycle [2] = '{17, 2};
      for (int k = 0; k < 2; k++) begin
         repeat (2) @(negedge clk);
         launch(0, 8'hFF);
         @(negedge clk); valid_all[0] = 1'b0;
         repeat (rst_cycle[k]) @(negedge clk);
         #2 rst_n = 1'b0;
         #1;
         checks++;
         if (tx_o[0] !== 1'b1 || ready_o[0] !== 1'b1 || done_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_frame at %0d: got tx/ready/done %b%b%b expected 110", rst_cycle[k],
                     tx_o[0], ready_o[0], done_o[0]);
         end
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         for (int t = 0; t < 45; t++) begin
            @(negedge clk);
            checks++;
            if (tx_o[0] !== 1'b1 || ready_o[0] !== 1'b1 || done_o[0] !== 1'b0) begin
               errors++;
               $display("FAIL reset_quiet cycle %0d: got tx/ready/done %b%b%b expected 110", t,
                        tx_o[0], ready_o[0], done_o[0]);
            end
         end
      end
      launch(0, 8'h3C);
      fork
         capture(0, 46);
         begin @(negedge clk); valid_all[0] = 1'b0; end
      join
      clear_expect();
      model_frame(0, 8'h3C, 0);
      for (int t = 0; t < 46; t++) begin
         checks++;
         if (cap_tx[t] !== exp_tx[t] || cap_ready[t] !== exp_ready[t] || cap_done[t] !== exp_done[t]) begin
            errors++;
            $display("FAIL after_reset cycle %0d: got tx/ready/done %b%b%b expected %b%b%b", t,
                     cap_tx[t], cap_ready[t], cap_done[t], exp_tx[t], exp_ready[t], exp_done[t]);
         end
      end
   endtask

   task automatic test_ignore_midframe();
      repeat (2) @(negedge clk);
      launch(0, 8'h81);
      fork
         capture(0, 88);
         begin
            @(negedge clk); valid_all[0] = 1'b0;
            repeat (10) @(negedge clk);
            valid_all[0] = 1'b1; data_all[7:0] = 8'h7E;
            repeat (31) @(negedge clk);
            valid_all[0] = 1'b0;
         end
      join
      clear_expect();
      model_frame(0, 8'h81, 0);
      model_frame(10 * C + 1, 8'h7E, 0);
      for (int t = 0; t < 88; t++) begin
         checks++;
         if (cap_tx[t] !== exp_tx[t] || cap_ready[t] !== exp_ready[t] || cap_done[t] !== exp_done[t]) begin
            errors++;
            $display("FAIL ignore_midframe cycle %0d: got tx/ready/done %b%b%b expected %b%b%b", t,
                     cap_tx[t], cap_ready[t], cap_done[t], exp_tx[t], exp_ready[t], exp_done[t]);
         end
      end
   endtask

   task automatic test_random();
      int inst;
      logic [7:0] d;
      for (int it = 0; it < 8; it++) begin
         inst = $urandom_range(0, 2);
         d = 8'($urandom);
         repeat ($urandom_range(1, 4)) @(negedge clk);
         launch(inst, d);
         fork
            capture(inst, 50);
            begin
               @(negedge clk); valid_all[inst] = 1'b0;
               repeat (30) begin
                  @(negedge clk);
                  data_all[inst*8 +: 8] = 8'($urandom);
               end
            end
         join
         clear_expect();
         model_frame(0, d, inst);
         for (int t = 0; t < 50; t++) begin
            checks++;
            if (cap_tx[t] !== exp_tx[t] || cap_ready[t] !== exp_ready[t] || cap_done[t] !== exp_done[t]) begin
               errors++;
               $display("FAIL random it %0d inst %0d data %h cycle %0d: got %b%b%b expected %b%b%b", it, inst, d, t,
                        cap_tx[t], cap_ready[t], cap_done[t], exp_tx[t], exp_ready[t], exp_done[t]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_parity();
      test_reset_mid_frame();
      test_ignore_midframe();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
